// File: rtl/apu_seq_pkg.sv
// Shared types and step-decode tables for the APU frame sequencer.
// Masks are indexed by the step value that is current when a step event fires.
package apu_seq_pkg;

   typedef logic [2:0] apu_step_t;

   localparam logic [7:0] LEN_STEP_MASK   = 8'b0101_0101;
   localparam logic [7:0] SWEEP_STEP_MASK = 8'b0100_0100;
   localparam logic [7:0] ENV_STEP_MASK   = 8'b1000_0000;

   typedef struct packed {
      logic len;
      logic sweep;
      logic env;
   } apu_ticks_t;

   function automatic apu_ticks_t decode_ticks(input apu_step_t s);
      apu_ticks_t t;
      t.len   = LEN_STEP_MASK[s];
      t.sweep = SWEEP_STEP_MASK[s];
      t.env   = ENV_STEP_MASK[s];
      return t;
   endfunction

endpackage

// File: rtl/apu_seq_edge_sync.sv
// Multi-flop synchronizer for a slow DIV-derived bit plus a falling-edge detector.
// fall_pulse is combinational from the flops so the consumer registers it one edge later.
module apu_seq_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic apuv_4mhz,
   input  logic apu_reset,
   input  logic in,
   output logic sync_out,
   output logic fall_pulse
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   hist_r;

   // Synchronizer chain and one-deep history of the synchronized bit.
   always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
      if (apu_reset) begin
         sync_r <= '0;
         hist_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], in};
         hist_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign sync_out   = sync_r[SYNC_STAGES-1];
   assign fall_pulse = hist_r & ~sync_out;

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 512 Hz step counter issuing length, sweep and envelope strobes.
// Optional macro APU_FAST_SEQ_EN adds test_fast, which steps every FAST_DIV clocks.
module apu_frame_sequencer
   import apu_seq_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FAST_DIV    = 16
) (
   input  logic       apuv_4mhz,
   input  logic       apu_reset,
   input  logic       div_bit,
`ifdef APU_FAST_SEQ_EN
   input  logic       test_fast,
`endif
   output logic       len_tick,
   output logic       sweep_tick,
   output logic       env_tick,
   output logic [2:0] step,
   output logic       len_next_skip
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || FAST_DIV < 2) begin : g_param_check
      $error("apu_frame_sequencer: parameter out of range");
   end

   logic       sync_s;
   logic       fall_s;
   logic       event_s;
   logic       div_mode_s;

   apu_step_t  step_r;
   apu_step_t  step_nxt_s;
   apu_ticks_t ticks_r;
   apu_ticks_t ticks_nxt_s;
   logic       skip_first_r;
   logic       skip_nxt_s;
   logic       skip_armed_r;
   logic       armed_nxt_s;
   logic [1:0] init_cnt_r;
   logic [1:0] init_cnt_nxt_s;

   apu_seq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_div_sync (
      .apuv_4mhz  (apuv_4mhz),
      .apu_reset  (apu_reset),
      .in         (div_bit),
      .sync_out   (sync_s),
      .fall_pulse (fall_s)
   );

`ifdef APU_FAST_SEQ_EN
   localparam int FAST_CNT_W = $clog2(FAST_DIV);

   logic [FAST_CNT_W-1:0] fast_cnt_r;
   logic                  fast_evt_s;

   assign fast_evt_s = test_fast && (fast_cnt_r == FAST_CNT_W'(FAST_DIV - 1));
   assign event_s    = test_fast ? fast_evt_s : fall_s;
   assign div_mode_s = ~test_fast;

   // Free-running fast-mode divider, parked at zero whenever test_fast is low.
   always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
      if (apu_reset) begin
         fast_cnt_r <= '0;
      end else if (!test_fast || fast_evt_s) begin
         fast_cnt_r <= '0;
      end else begin
         fast_cnt_r <= fast_cnt_r + FAST_CNT_W'(1);
      end
   end
`else
   assign event_s    = fall_s;
   assign div_mode_s = 1'b1;
`endif

   // Step advance, strobe decode and power-on skip bookkeeping.
   always_comb begin
      step_nxt_s     = step_r;
      ticks_nxt_s    = '0;
      skip_nxt_s     = skip_first_r;
      armed_nxt_s    = skip_armed_r;
      init_cnt_nxt_s = init_cnt_r;

      if (event_s) begin
         if (div_mode_s && skip_first_r) begin
            skip_nxt_s = 1'b0;
         end else begin
            ticks_nxt_s = decode_ticks(step_r);
            step_nxt_s  = step_r + 3'd1;
         end
      end else begin
         step_nxt_s = step_r;
      end

      // The synchronizer is cleared by reset, so div_bit is sampled once it has flushed through.
      if (!skip_armed_r) begin
         if (init_cnt_r == 2'(SYNC_STAGES)) begin
            armed_nxt_s = 1'b1;
            skip_nxt_s  = sync_s;
         end else begin
            init_cnt_nxt_s = init_cnt_r + 2'd1;
         end
      end else begin
         init_cnt_nxt_s = init_cnt_r;
      end
   end

   // State and output registers.
   always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
      if (apu_reset) begin
         step_r       <= 3'd0;
         ticks_r      <= '0;
         skip_first_r <= 1'b0;
         skip_armed_r <= 1'b0;
         init_cnt_r   <= 2'd0;
      end else begin
         step_r       <= step_nxt_s;
         ticks_r      <= ticks_nxt_s;
         skip_first_r <= skip_nxt_s;
         skip_armed_r <= armed_nxt_s;
         init_cnt_r   <= init_cnt_nxt_s;
      end
   end

   assign len_tick      = ticks_r.len;
   assign sweep_tick    = ticks_r.sweep;
   assign env_tick      = ticks_r.env;
   assign step          = step_r;
   assign len_next_skip = ~step_r[0];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed, table-driven bench for apu_frame_sequencer (SYNC_STAGES 2 and 3 instances).
module tb_apu_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       div_bit;
   logic       test_fast;
   logic       len2, sweep2, env2, lns2;
   logic [2:0] step2;
   logic       len3, sweep3, env3, lns3;
   logic [2:0] step3;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic       len;
      logic       sweep;
      logic       env;
      logic [2:0] step;
      logic       lns;
   } vec_t;

   vec_t tbl[8];

   always #5 clk = ~clk;

   apu_frame_sequencer #(.SYNC_STAGES(2), .FAST_DIV(16)) dut (
      .apuv_4mhz     (clk),
      .apu_reset     (rst),
      .div_bit       (div_bit),
`ifdef APU_FAST_SEQ_EN
      .test_fast     (test_fast),
`endif
      .len_tick      (len2),
      .sweep_tick    (sweep2),
      .env_tick      (env2),
      .step          (step2),
      .len_next_skip (lns2)
   );

   apu_frame_sequencer #(.SYNC_STAGES(3), .FAST_DIV(16)) dut3 (
      .apuv_4mhz     (clk),
      .apu_reset     (rst),
      .div_bit       (div_bit),
`ifdef APU_FAST_SEQ_EN
      .test_fast     (test_fast),
`endif
      .len_tick      (len3),
      .sweep_tick    (sweep3),
      .env_tick      (env3),
      .step          (step3),
      .len_next_skip (lns3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One div_bit high/low period (64 clocks), checking latency on both instances.
   task automatic do_fall(input logic [2:0] prev, input vec_t v);
      div_bit = 1'b1;
      cyc(32);
      div_bit = 1'b0;
      cyc(2);
      chk("early_step", step2, prev);
      chk("early_len", len2, 1'b0);
      cyc(1);
      chk("len_tick", len2, v.len);
      chk("sweep_tick", sweep2, v.sweep);
      chk("env_tick", env2, v.env);
      chk("step", step2, v.step);
      chk("len_next_skip", lns2, v.lns);
      chk("s3_early_step", step3, prev);
      cyc(1);
      chk("strobe_width", {len2, sweep2, env2}, 3'b000);
      chk("step_hold", step2, v.step);
      chk("s3_len", len3, v.len);
      chk("s3_sweep", sweep3, v.sweep);
      chk("s3_env", env3, v.env);
      chk("s3_step", step3, v.step);
      cyc(1);
      chk("s3_strobe_width", {len3, sweep3, env3}, 3'b000);
      cyc(27);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] prev;
      logic [2:0] any_tick;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 3'd5, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 3'd6, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 3'd7, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1};

      // Reset state
      rst = 1'b1; div_bit = 1'b0; test_fast = 1'b0;
      cyc(3);
      chk("rst_step", step2, 3'd0);
      chk("rst_ticks", {len2, sweep2, env2}, 3'b000);
      chk("rst_lns", lns2, 1'b1);
      chk("rst_step3", step3, 3'd0);
      rst = 1'b0;
      cyc(10);

      // Full frame of eight steps
      prev = 3'd0;
      for (int i = 0; i < 8; i++) begin
         do_fall(prev, tbl[i]);
         prev = tbl[i].step;
      end

      // Power-on skip: div_bit high at release
      rst = 1'b1; div_bit = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(10);
      div_bit = 1'b0;
      any_tick = 3'b000;
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         any_tick = any_tick | {len2, sweep2, env2} | {len3, sweep3, env3};
      end
      chk("skip_no_strobe", any_tick, 3'b000);
      chk("skip_step", step2, 3'd0);
      chk("skip_step3", step3, 3'd0);
      div_bit = 1'b1;
      cyc(32);
      div_bit = 1'b0;
      cyc(3);
      chk("skip2_len", len2, 1'b1);
      chk("skip2_step", step2, 3'd1);
      cyc(1);
      chk("skip2_len3", len3, 1'b1);
      chk("skip2_step3", step3, 3'd1);
      cyc(20);

      // Async reset mid-frame with an edge in flight
      rst = 1'b1; div_bit = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(10);
      prev = 3'd0;
      for (int i = 0; i < 5; i++) begin
         do_fall(prev, tbl[i]);
         prev = tbl[i].step;
      end
      chk("pre_rst_step", step2, 3'd5);
      div_bit = 1'b1;
      cyc(32);
      div_bit = 1'b0;
      cyc(1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_step", step2, 3'd0);
      chk("async_rst_ticks", {len2, sweep2, env2}, 3'b000);
      chk("async_rst_step3", step3, 3'd0);
      cyc(2);
      rst = 1'b0;
      any_tick = 3'b000;
      for (int k = 0; k < 10; k++) begin
         cyc(1);
         any_tick = any_tick | {len2, sweep2, env2} | {len3, sweep3, env3};
      end
      chk("discard_no_strobe", any_tick, 3'b000);
      chk("discard_step", step2, 3'd0);
      chk("discard_step3", step3, 3'd0);

`ifdef APU_FAST_SEQ_EN
      // Fast test mode: one step per 16 clocks, div_bit ignored
      rst = 1'b1; test_fast = 1'b1; div_bit = 1'b0;
      cyc(2);
      rst = 1'b0;
      for (int k = 1; k <= 96; k++) begin
         cyc(1);
         if (k == 47) chk("fast_len_47", len2, 1'b0);
         if (k == 48) chk("fast_sweep_48", sweep2, 1'b1);
         if (k == 48) chk("fast_len_48", len2, 1'b1);
         if (k == 95) chk("fast_step_95", step2, 3'd5);
         if (k == 96) chk("fast_step_96", step2, 3'd6);
         if (k >= 10 && k < 80 && (k % 3) == 0) div_bit = ~div_bit;
         if (k == 80) div_bit = 1'b1;
      end
      test_fast = 1'b0;
      cyc(10);
      chk("fast_hold_step", step2, 3'd6);
      div_bit = 1'b0;
      cyc(3);
      chk("fast_exit_sweep", sweep2, 1'b1);
      chk("fast_exit_len", len2, 1'b1);
      chk("fast_exit_step", step2, 3'd7);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
